// File: rtl/ten_eth_tx.sv
// ten_eth_tx: store-and-forward egress path from the crossbar to a 10G MAC TX.
// Each frame is buffered whole, optionally gets its source MAC replaced with
// this port's MAC, and is then streamed out without mid-frame bubbles.
// Runts, oversize frames, discard-flagged frames and frames arriving while
// the link is down are dropped and counted.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_stat_tx_status        MAC TX link up
//   s_axis_*                frame input from the crossbar (tuser 2'b11 = discard)
//   m_axis_tx_*             frame output to the MAC (tuser always 0)
//   o_tx_pkt_cnt            frames fully sent (wraps)
//   o_drop_cnt              frames dropped (wraps)
//   o_tx_port_id            constant port index
module ten_eth_tx #(
   parameter int          P_TX_PORT_ID  = 0,
   parameter logic [47:0] P_MY_PORT_MAC = 48'h8D_BC_5C_4A_00_01,
   parameter bit          P_SRC_REWRITE = 1'b1,
   parameter int          P_DATA_DEPTH  = 256,
   parameter int          P_DESC_DEPTH  = 16,
   parameter int          P_MAX_WORDS   = 200
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stat_tx_status,
   input  logic        s_axis_tvalid,
   input  logic [63:0] s_axis_tdata,
   input  logic        s_axis_tlast,
   input  logic [7:0]  s_axis_tkeep,
   input  logic [1:0]  s_axis_tuser,
   output logic        s_axis_tready,
   output logic        m_axis_tx_tvalid,
   output logic [63:0] m_axis_tx_tdata,
   output logic        m_axis_tx_tlast,
   output logic [7:0]  m_axis_tx_tkeep,
   output logic        m_axis_tx_tuser,
   input  logic        m_axis_tx_tready,
   output logic [15:0] o_tx_pkt_cnt,
   output logic [15:0] o_drop_cnt,
   output logic [3:0]  o_tx_port_id
);

   localparam int AW = $clog2(P_DATA_DEPTH);
   localparam int DW = $clog2(P_DESC_DEPTH);
   localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0] DEPTH_W   = (AW+1)'(P_DATA_DEPTH);
   localparam logic [AW:0] MAX_W     = (AW+1)'(P_MAX_WORDS);
   localparam logic [DW:0] DPTR_ONE  = (DW+1)'(1);
   localparam logic [DW:0] DDEPTH_W  = (DW+1)'(P_DESC_DEPTH);
   localparam logic [15:0] MAX16     = 16'(P_MAX_WORDS);

   typedef enum logic {W_IDLE, W_RECV} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} rstate_t;

   logic [63:0] data_mem [P_DATA_DEPTH];
   logic [23:0] desc_mem [P_DESC_DEPTH];   // {len_words, last_tkeep}

   wstate_t     wstate_reg;
   rstate_t     rstate_reg;
   logic [AW:0] wr_ptr_reg;     // end of committed data
   logic [AW:0] wr_tmp_reg;     // write position inside the frame being received
   logic [AW:0] free_ptr_reg;   // start of the oldest frame not yet freed
   logic [AW:0] rd_ptr_reg;     // next word to fetch for transmit
   logic [DW:0] dwr_reg;
   logic [DW:0] drd_reg;
   logic [15:0] wcnt_reg;       // index of the next incoming word, saturates at max
   logic        drop_reg;
   logic [15:0] len_reg;
   logic [7:0]  keep_reg;
   logic [15:0] bcnt_reg;       // index of the word currently on the output

   logic [AW:0] used_words;
   logic [AW:0] free_words;
   logic        room;
   logic        desc_full;
   logic        desc_empty;
   logic        hs;
   logic        mem_we;
   logic        word_drop;
   logic        frame_drop;
   logic [15:0] len_now;
   logic        commit;
   logic [63:0] wdata;
   logic [23:0] desc_q;
   logic [15:0] bcnt_nxt;

   // Freed space is tracked by pointer difference, so a commit and a free
   // landing in the same cycle both take effect.
   assign used_words = wr_ptr_reg - free_ptr_reg;
   assign free_words = DEPTH_W - used_words;
   assign room       = (free_words >= MAX_W);
   assign desc_full  = ((dwr_reg - drd_reg) == DDEPTH_W);
   assign desc_empty = (dwr_reg == drd_reg);

   assign hs         = s_axis_tvalid && s_axis_tready;
   assign mem_we     = hs && (wcnt_reg < MAX16);
   assign word_drop  = ((wcnt_reg == 16'd0) && ((s_axis_tdata[7:0] == 8'h00) || !i_stat_tx_status))
                    || (s_axis_tuser == 2'b11)
                    || ((wcnt_reg >= (MAX16 - 16'd1)) && !s_axis_tlast);
   assign frame_drop = drop_reg || word_drop;
   assign len_now    = wcnt_reg + 16'd1;
   assign commit     = hs && s_axis_tlast && !frame_drop && (len_now >= 16'd3);
   assign desc_q     = desc_mem[drd_reg[DW-1:0]];
   assign bcnt_nxt   = bcnt_reg + 16'd1;

   assign m_axis_tx_tuser = 1'b0;
   assign o_tx_port_id    = 4'(P_TX_PORT_ID);

   always_comb begin
      wdata = s_axis_tdata;
      if (P_SRC_REWRITE) begin
         if (wcnt_reg == 16'd1)
            wdata[15:0] = P_MY_PORT_MAC[47:32];
         else if (wcnt_reg == 16'd2)
            wdata[63:32] = P_MY_PORT_MAC[31:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_we)
         data_mem[wr_tmp_reg[AW-1:0]] <= wdata;
      if (commit)
         desc_mem[dwr_reg[DW-1:0]] <= {len_now, s_axis_tkeep};
   end

   // Write side. tready drops for one cycle after every tlast and is then
   // re-evaluated; while idle, room can only grow, so a stale 1 is safe.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wstate_reg    <= W_IDLE;
         s_axis_tready <= 1'b0;
         wr_ptr_reg    <= '0;
         wr_tmp_reg    <= '0;
         dwr_reg       <= '0;
         wcnt_reg      <= '0;
         drop_reg      <= 1'b0;
         o_drop_cnt    <= '0;
      end else if (hs) begin
         if (mem_we)
            wr_tmp_reg <= wr_tmp_reg + PTR_ONE;
         if (s_axis_tlast) begin
            wstate_reg    <= W_IDLE;
            s_axis_tready <= 1'b0;
            wcnt_reg      <= '0;
            drop_reg      <= 1'b0;
            if (commit) begin
               wr_ptr_reg <= wr_tmp_reg + PTR_ONE;
               dwr_reg    <= dwr_reg + DPTR_ONE;
            end else begin
               wr_tmp_reg <= wr_ptr_reg;
               o_drop_cnt <= o_drop_cnt + 16'd1;
            end
         end else begin
            wstate_reg    <= W_RECV;
            s_axis_tready <= 1'b1;
            drop_reg      <= frame_drop;
            if (wcnt_reg < MAX16)
               wcnt_reg <= wcnt_reg + 16'd1;
         end
      end else if (wstate_reg == W_IDLE) begin
         s_axis_tready <= room && !desc_full;
      end
   end

   // Read side. The output register is loaded straight from the buffer, and
   // the next word is fetched only when the current one is taken.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rstate_reg       <= R_IDLE;
         rd_ptr_reg       <= '0;
         free_ptr_reg     <= '0;
         drd_reg          <= '0;
         len_reg          <= '0;
         keep_reg         <= 8'hFF;
         bcnt_reg         <= '0;
         m_axis_tx_tvalid <= 1'b0;
         m_axis_tx_tdata  <= '0;
         m_axis_tx_tlast  <= 1'b0;
         m_axis_tx_tkeep  <= 8'hFF;
         o_tx_pkt_cnt     <= '0;
      end else begin
         case (rstate_reg)
            R_IDLE: begin
               if (!desc_empty && i_stat_tx_status)
                  rstate_reg <= R_LOAD;
            end
            R_LOAD: begin
               len_reg          <= desc_q[23:8];
               keep_reg         <= desc_q[7:0];
               drd_reg          <= drd_reg + DPTR_ONE;
               m_axis_tx_tdata  <= data_mem[rd_ptr_reg[AW-1:0]];
               rd_ptr_reg       <= rd_ptr_reg + PTR_ONE;
               bcnt_reg         <= '0;
               m_axis_tx_tvalid <= 1'b1;
               m_axis_tx_tlast  <= (desc_q[23:8] == 16'd1);
               m_axis_tx_tkeep  <= (desc_q[23:8] == 16'd1) ? desc_q[7:0] : 8'hFF;
               rstate_reg       <= R_SEND;
            end
            R_SEND: begin
               if (m_axis_tx_tvalid && m_axis_tx_tready) begin
                  if (m_axis_tx_tlast) begin
                     m_axis_tx_tvalid <= 1'b0;
                     m_axis_tx_tlast  <= 1'b0;
                     m_axis_tx_tkeep  <= 8'hFF;
                     free_ptr_reg     <= rd_ptr_reg;
                     o_tx_pkt_cnt     <= o_tx_pkt_cnt + 16'd1;
                     rstate_reg       <= (!desc_empty && i_stat_tx_status) ? R_LOAD : R_IDLE;
                  end else begin
                     m_axis_tx_tdata <= data_mem[rd_ptr_reg[AW-1:0]];
                     rd_ptr_reg      <= rd_ptr_reg + PTR_ONE;
                     bcnt_reg        <= bcnt_nxt;
                     m_axis_tx_tlast <= (bcnt_nxt == (len_reg - 16'd1));
                     m_axis_tx_tkeep <= (bcnt_nxt == (len_reg - 16'd1)) ? keep_reg : 8'hFF;
                  end
               end
            end
            default: rstate_reg <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ten_eth_tx.sv
// tb_ten_eth_tx: randomized scoreboard bench for ten_eth_tx. The stimulus
// side decides from the frame rules whether each frame survives and queues
// its expected beats; a forked monitor pops and compares every output beat.
`timescale 1ns/1ps
module tb_ten_eth_tx;

   localparam int          DEPTH = 256;
   localparam int          DESC  = 16;
   localparam int          MAXW  = 200;
   localparam logic [47:0] MAC   = 48'h8D_BC_5C_4A_00_01;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        link = 1'b1;
   logic        s_tvalid = 1'b0;
   logic [63:0] s_tdata = '0;
   logic        s_tlast = 1'b0;
   logic [7:0]  s_tkeep = 8'hFF;
   logic [1:0]  s_tuser = 2'b00;
   logic        s_tready;
   logic        m_tvalid;
   logic [63:0] m_tdata;
   logic        m_tlast;
   logic [7:0]  m_tkeep;
   logic        m_tuser;
   logic        m_ready = 1'b1;
   logic [15:0] pkt_cnt;
   logic [15:0] drop_cnt;
   logic [3:0]  port_id;

   logic [47:0] mac_v = MAC;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ten_eth_tx #(
      .P_TX_PORT_ID (0),
      .P_MY_PORT_MAC(MAC),
      .P_SRC_REWRITE(1'b1),
      .P_DATA_DEPTH (DEPTH),
      .P_DESC_DEPTH (DESC),
      .P_MAX_WORDS  (MAXW)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_stat_tx_status(link),
      .s_axis_tvalid   (s_tvalid),
      .s_axis_tdata    (s_tdata),
      .s_axis_tlast    (s_tlast),
      .s_axis_tkeep    (s_tkeep),
      .s_axis_tuser    (s_tuser),
      .s_axis_tready   (s_tready),
      .m_axis_tx_tvalid(m_tvalid),
      .m_axis_tx_tdata (m_tdata),
      .m_axis_tx_tlast (m_tlast),
      .m_axis_tx_tkeep (m_tkeep),
      .m_axis_tx_tuser (m_tuser),
      .m_axis_tx_tready(m_ready),
      .o_tx_pkt_cnt    (pkt_cnt),
      .o_drop_cnt      (drop_cnt),
      .o_tx_port_id    (port_id)
   );

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   beat_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int exp_sent = 0;
   int exp_drop = 0;
   int frames_acc = 0;
   int beats_seen = 0;
   int first_valid_edge = 0;
   int last_hs_edge = 0;
   int ready_mode = 1;   // 0 stall, 1 ready, 2 toggle, 3 random

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Builds a frame, predicts its fate from the frame rules, then drives it.
   task automatic send_frame(input int n, input logic [7:0] lkeep, input logic [7:0] b0, input int bad_at);
      logic [63:0] words[$];
      logic [1:0]  users[$];
      logic [63:0] w;
      beat_t       b;
      bit          drop;
      int          bound;
      for (int i = 0; i < n; i++) begin
         w = {$urandom, $urandom};
         if (i == 0) w[7:0] = b0;
         words.push_back(w);
         users.push_back((i == bad_at) ? 2'b11 : 2'($urandom_range(0, 2)));
      end
      drop = (n < 3) || (n > MAXW) || (b0 == 8'h00) || (bad_at >= 0 && bad_at < n) || !link;
      $display("frame len=%0d b0=%h bad_user=%0d link=%0b keep=%h -> %s",
               n, b0, bad_at, link, lkeep, drop ? "drop" : "send");
      if (!drop) begin
         for (int i = 0; i < n; i++) begin
            b.d = words[i];
            if (i == 1) b.d[15:0]  = mac_v[47:32];
            if (i == 2) b.d[63:32] = mac_v[31:0];
            b.k = (i == n - 1) ? lkeep : 8'hFF;
            b.l = (i == n - 1);
            exp_q.push_back(b);
         end
         exp_sent++;
      end else begin
         exp_drop++;
      end
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         s_tvalid = 1'b1;
         s_tdata  = words[i];
         s_tuser  = users[i];
         s_tlast  = (i == n - 1);
         s_tkeep  = (i == n - 1) ? lkeep : 8'($urandom);
         bound = 0;
         while (!s_tready && bound < 5000) begin
            @(negedge clk);
            bound++;
         end
         if (bound >= 5000) begin
            checks++;
            errors++;
            $display("FAIL ingress_timeout actual=tready_low required=accept word %0d", i);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            return;
         end
         if (i == n - 1) begin
            last_hs_edge = cyc + 1;
            frames_acc++;
         end
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic run_monitor();
      beat_t       b;
      bit          in_frame = 0;
      bit          stalled = 0;
      bit          gap_next = 0;
      bit          prev_v = 0;
      logic [63:0] held_d = '0;
      logic [7:0]  held_k = '0;
      logic        held_l = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_frame = 0;
            stalled  = 0;
            gap_next = 0;
            prev_v   = 0;
         end else begin
            if (stalled) begin
               check("stall_data", m_tdata, held_d);
               check("stall_ctl", 64'({m_tvalid, m_tlast, m_tkeep}), 64'({1'b1, held_l, held_k}));
            end
            if (in_frame) check("no_bubble", 64'(m_tvalid), 64'd1);
            if (gap_next) check("ifg", 64'(m_tvalid), 64'd0);
            gap_next = 0;
            if (m_tvalid && !prev_v) first_valid_edge = cyc;
            if (m_tvalid && m_ready) begin
               beats_seen++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat actual=%h required=none", m_tdata);
               end else begin
                  b = exp_q.pop_front();
                  check("beat_data", m_tdata, b.d);
                  check("beat_ctl", 64'({m_tkeep, m_tlast, m_tuser}), 64'({b.k, b.l, 1'b0}));
               end
               in_frame = !m_tlast;
               gap_next = m_tlast;
            end
            stalled = m_tvalid && !m_ready;
            held_d  = m_tdata;
            held_k  = m_tkeep;
            held_l  = m_tlast;
            prev_v  = m_tvalid;
         end
      end
   endtask

   task automatic run_ready();
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom);
         endcase
      end
   endtask

   task automatic wait_drain();
      int b = 0;
      while ((exp_q.size() != 0 || m_tvalid) && b < 20000) begin
         @(negedge clk);
         b++;
      end
      check("drain_done", 64'(b < 20000), 64'd1);
      repeat (5) @(negedge clk);
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(16'(exp_sent)));
      check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(16'(exp_drop)));
   endtask

   // Stalls the MAC, offers nf frames of nw words, and checks how many get in
   // before ingress backpressure: limited by free words or descriptor slots,
   // with one frame already popped into the transmit stage.
   task automatic stall_burst(input int nf, input int nw);
      int base = frames_acc;
      int expn;
      expn = (DEPTH - MAXW) / nw + 1;
      if (expn > DESC + 1) expn = DESC + 1;
      if (expn > nf) expn = nf;
      ready_mode = 0;
      fork
         begin
            for (int i = 0; i < nf; i++)
               send_frame(nw, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), -1);
         end
         begin
            repeat (400) @(negedge clk);
            check("stall_accepted", 64'(frames_acc - base), 64'(expn));
            check("stall_tready", 64'(s_tready), 64'd0);
            ready_mode = 1;
         end
      join
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      int base;
      int b;
      logic [7:0] b0;
      fork
         run_monitor();
         run_ready();
      join_none

      // Reset values
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_tlast", 64'(m_tlast), 64'd0);
      check("rst_tdata", m_tdata, 64'd0);
      check("rst_tkeep", 64'(m_tkeep), 64'hFF);
      check("rst_tready", 64'(s_tready), 64'd0);
      check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      check("port_id", 64'(port_id), 64'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("tready_after_reset", 64'(s_tready), 64'd1);

      // Single 8-word frame and its latency
      ready_mode = 1;
      send_frame(8, 8'h0F, 8'h55, -1);
      wait_drain();
      check("latency", 64'(first_valid_edge - last_hs_edge), 64'd2);
      check_counters("single");

      // Runt by byte0, 2-word runt, discard flag, then a good frame
      send_frame(6, 8'hFF, 8'h00, -1);
      send_frame(2, 8'hFF, 8'h11, -1);
      send_frame(5, 8'hFF, 8'h22, 3);
      send_frame(7, 8'h01, 8'h33, -1);
      wait_drain();
      check_counters("drops");

      // Link down at the first word
      link = 1'b0;
      send_frame(5, 8'hFF, 8'h44, -1);
      link = 1'b1;
      send_frame(1, 8'hFF, 8'h45, -1);
      wait_drain();
      check_counters("link_down");

      // Oversize, exact maximum, one past maximum, then space recovery
      send_frame(210, 8'hFF, 8'h66, -1);
      wait_drain();
      check_counters("oversize");
      send_frame(MAXW, 8'h7F, 8'h67, -1);
      send_frame(MAXW + 1, 8'h7F, 8'h68, -1);
      wait_drain();
      check_counters("max_len");
      for (int i = 0; i < 16; i++) send_frame(8, 8'($urandom_range(1, 255)), 8'h69, -1);
      wait_drain();
      check_counters("recovery");

      // MAC ready toggling every cycle
      ready_mode = 2;
      send_frame(10, 8'h3F, 8'h77, -1);
      wait_drain();
      check_counters("toggle");

      // Backpressure by free space, then by descriptor slots
      stall_burst(16, 16);
      wait_drain();
      check_counters("burst16");
      stall_burst(20, 3);
      wait_drain();
      check_counters("burst3");

      // Randomized traffic with random MAC readiness
      ready_mode = 3;
      for (int i = 0; i < 25; i++) begin
         n   = $urandom_range(1, 14);
         b0  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n - 1) : -1;
         send_frame(n, 8'($urandom), b0, bad);
      end
      ready_mode = 1;
      wait_drain();
      check_counters("random");

      // Reset in the middle of a transmit
      base = beats_seen;
      send_frame(20, 8'h0F, 8'h88, -1);
      b = 0;
      while (beats_seen < base + 5 && b < 2000) begin
         @(negedge clk);
         b++;
      end
      check("reset_wait", 64'(b < 2000), 64'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
      check("mid_rst_tlast", 64'(m_tlast), 64'd0);
      check("mid_rst_tdata", m_tdata, 64'd0);
      check("mid_rst_tkeep", 64'(m_tkeep), 64'hFF);
      check("mid_rst_tready", 64'(s_tready), 64'd0);
      check("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      exp_q.delete();
      exp_sent = 0;
      exp_drop = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send_frame(9, 8'h03, 8'h99, -1);
      wait_drain();
      check_counters("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
